// File: rtl/drbg_pkg.sv
// drbg_pkg: shared definitions for the double_hash_drbg wrapper and the key
// unpacker that sits behind it.
//   DEF_WORD_WIDTH / DEF_KEY_WIDTH : default random_bits and key widths
//   drbg_state_e                   : request FSM encodings (S_INIT..S_RELEASE)
//   lane_width()                   : lane index width, never narrower than 1
package drbg_pkg;

  localparam int DEF_WORD_WIDTH = 256;
  localparam int DEF_KEY_WIDTH  = 32;

  typedef enum logic [1:0] {
    S_INIT    = 2'd0,
    S_IDLE    = 2'd1,
    S_REQ     = 2'd2,
    S_RELEASE = 2'd3
  } drbg_state_e;

  function automatic int lane_width(input int lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

endpackage

// File: rtl/drbg_word_buffer.sv
// drbg_word_buffer: two-slot FIFO of DRBG words, emitted as KEY_WIDTH keys,
// least-significant lane first, over a valid/ready port.
//   clk, rst_n      : clock, asynchronous active-low reset
//   flush           : empties both slots and rewinds pointers / lane
//   wr_en, wr_data  : capture one word into the write slot
//   free            : at least one slot is empty
//   key_ready       : consumer accepts the current key
//   key_valid       : read slot holds a word
//   key_data        : registered key of the current lane
//   key_lane        : lane index of key_data within its word
module drbg_word_buffer
  import drbg_pkg::*;
#(
  parameter int  WORD_WIDTH = DEF_WORD_WIDTH,
  parameter int  KEY_WIDTH  = DEF_KEY_WIDTH,
  localparam int LANES      = WORD_WIDTH / KEY_WIDTH,
  localparam int LANE_W     = lane_width(LANES)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [WORD_WIDTH-1:0] wr_data,
  output logic                  free,
  input  logic                  key_ready,
  output logic                  key_valid,
  output logic [KEY_WIDTH-1:0]  key_data,
  output logic [LANE_W-1:0]     key_lane
);

  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

  logic [WORD_WIDTH-1:0] slot_q [2];
  logic [1:0]            full_q;
  logic                  rd_ptr_q;
  logic                  wr_ptr_q;
  logic [LANE_W-1:0]     lane_q;

  logic [1:0]            full_d;
  logic                  rd_ptr_d;
  logic                  wr_ptr_d;
  logic [LANE_W-1:0]     lane_d;
  logic                  wr_slot;
  logic                  xfer;
  logic [WORD_WIDTH-1:0] out_word;

  assign key_valid = full_q[rd_ptr_q];
  assign key_lane  = lane_q;
  assign free      = ~&full_q;
  assign xfer      = key_valid & key_ready;
  // A word returning in the flush cycle lands in slot 0 of the rewound buffer.
  assign wr_slot   = flush ? 1'b0 : wr_ptr_q;

  always_comb begin
    full_d   = full_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    lane_d   = lane_q;
    if (flush) begin
      full_d   = '0;
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      lane_d   = '0;
    end else if (xfer) begin
      if (lane_q == LAST_LANE) begin
        lane_d           = '0;
        full_d[rd_ptr_q] = 1'b0;
        rd_ptr_d         = ~rd_ptr_q;
      end else begin
        lane_d = lane_q + LANE_W'(1);
      end
    end
    if (wr_en) begin
      full_d[wr_slot] = 1'b1;
      wr_ptr_d        = ~wr_slot;
    end
    // key_data is registered, so it must come from next-cycle state; bypass
    // the word being captured when it lands in the slot about to be read.
    out_word = (wr_en && (wr_slot == rd_ptr_d)) ? wr_data : slot_q[rd_ptr_d];
  end

  // Control state and output key register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q   <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      lane_q   <= '0;
      key_data <= '0;
    end else begin
      full_q   <= full_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      lane_q   <= lane_d;
      key_data <= out_word[lane_d*KEY_WIDTH +: KEY_WIDTH];
    end
  end

  // Word storage
  always_ff @(posedge clk) begin
    if (wr_en) slot_q[wr_slot] <= wr_data;
  end

endmodule

// File: rtl/drbg_key_unpacker.sv
// drbg_key_unpacker: drives the DRBG init / next_bits request pins, keeps up
// to two random_bits words buffered and hands them out as scramble keys.
//   clk, reset_n            : clock, asynchronous active-low reset
//   init, init_ready        : DRBG instantiation handshake
//   next_bits, next_bits_ready, random_bits : DRBG word request / return
//   flush                   : discard buffered keys (frame resync)
//   key_ready, key_valid, key_data, key_lane : key stream to the scrambler
//   underrun                : sticky; consumer asked while no key was ready
//   drbg_up                 : DRBG instantiated
module drbg_key_unpacker
  import drbg_pkg::*;
#(
  parameter int  WORD_WIDTH = DEF_WORD_WIDTH,
  parameter int  KEY_WIDTH  = DEF_KEY_WIDTH,
  localparam int LANES      = WORD_WIDTH / KEY_WIDTH,
  localparam int LANE_W     = lane_width(LANES)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  output logic                  init,
  input  logic                  init_ready,
  output logic                  next_bits,
  input  logic                  next_bits_ready,
  input  logic [WORD_WIDTH-1:0] random_bits,
  input  logic                  flush,
  input  logic                  key_ready,
  output logic                  key_valid,
  output logic [KEY_WIDTH-1:0]  key_data,
  output logic [LANE_W-1:0]     key_lane,
  output logic                  underrun,
  output logic                  drbg_up
);

  drbg_state_e state_q;
  logic        capture;
  logic        free;

  // One request outstanding at most, so the word returned in S_REQ always
  // has a free slot waiting for it.
  assign capture = (state_q == S_REQ) && next_bits_ready;

  drbg_word_buffer #(
    .WORD_WIDTH(WORD_WIDTH),
    .KEY_WIDTH (KEY_WIDTH)
  ) u_buf (
    .clk      (clk),
    .rst_n    (reset_n),
    .flush    (flush),
    .wr_en    (capture),
    .wr_data  (random_bits),
    .free     (free),
    .key_ready(key_ready),
    .key_valid(key_valid),
    .key_data (key_data),
    .key_lane (key_lane)
  );

  // Request FSM
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_INIT;
      init      <= 1'b0;
      next_bits <= 1'b0;
      drbg_up   <= 1'b0;
    end else if (drbg_up && !init_ready) begin
      // DRBG reseed: re-instantiate; buffered keys stay deliverable.
      state_q   <= S_INIT;
      init      <= 1'b1;
      next_bits <= 1'b0;
      drbg_up   <= 1'b0;
    end else begin
      case (state_q)
        S_INIT: begin
          if (init_ready) begin
            init    <= 1'b0;
            drbg_up <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            init <= 1'b1;
          end
        end
        S_IDLE: begin
          if (free && !next_bits_ready) begin
            next_bits <= 1'b1;
            state_q   <= S_REQ;
          end
        end
        S_REQ: begin
          if (next_bits_ready) begin
            next_bits <= 1'b0;
            state_q   <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          if (!next_bits_ready) state_q <= S_IDLE;
        end
        default: state_q <= S_INIT;
      endcase
    end
  end

  // Sticky underrun flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) underrun <= 1'b0;
    else if (key_ready && !key_valid && drbg_up) underrun <= 1'b1;
  end

endmodule

// File: doc/drbg_key_unpacker.md
Name: drbg_key_unpacker

Overview:
Sits directly downstream of double_hash_drbg and drives its init / next_bits request pins. It captures each 256-bit random_bits word into a two-slot buffer and hands it out as KEY_WIDTH-bit scramble keys, least-significant lane first, over a valid/ready port to the line scrambler. It prefetches one word ahead so the scrambler never waits on hash latency in steady state.

Parameters:
WORD_WIDTH, 256, width of DRBG random_bits.
KEY_WIDTH, 32, width of one key; WORD_WIDTH must be an integer multiple of it.
LANES, WORD_WIDTH/KEY_WIDTH (8), keys per word; derived, not overridable.

Ports:
clk  in  1  system clock.
reset_n  in  1  asynchronous active-low reset.
init  out  1  to DRBG init; request instantiation/reseed.
init_ready  in  1  from DRBG; high once instantiated.
next_bits  out  1  to DRBG next_bits request.
next_bits_ready  in  1  from DRBG; rises when random_bits is valid.
random_bits  in  WORD_WIDTH  from DRBG.
flush  in  1  one-cycle pulse; discards buffered keys (frame resync).
key_ready  in  1  consumer accepts key this cycle.
key_valid  out  1  key_data holds a valid key.
key_data  out  KEY_WIDTH  current key.
key_lane  out  log2(LANES)  lane index of key_data within its word.
underrun  out  1  sticky; set when key_ready=1 while key_valid=0 after drbg_up.
drbg_up  out  1  high once init_ready has been seen.

Behaviour:
- Reset (async, any cycle, including mid-request): all outputs 0; both slots empty; FSM to S_INIT; lane counter 0.
- Request FSM states: S_INIT, S_IDLE, S_REQ, S_RELEASE.
  - S_INIT: init=1 until init_ready=1 sampled high; then init=0, drbg_up=1, go to S_IDLE.
  - S_IDLE: next_bits=0. Go to S_REQ when at least one slot is free and next_bits_ready=0.
  - S_REQ: next_bits=1. On the first cycle next_bits_ready is sampled 1, write random_bits into the free slot, drop next_bits, and go to S_RELEASE.
  - S_RELEASE: next_bits=0. Wait for next_bits_ready=0, then go to S_IDLE. There is never more than one outstanding request.
- Init handling: init_ready falling after drbg_up (DRBG reseed) clears drbg_up and returns the FSM to S_INIT. Buffered keys remain deliverable.
- Buffer:
  - Two slots, FIFO order, with per-slot full flag.
  - A capture writes slot wr_ptr; wr_ptr toggles.
  - The output reads slot rd_ptr.
- Output timing:
  - key_valid=1 whenever slot rd_ptr is full.
  - key_data = slot[rd_ptr][key_lane*KEY_WIDTH +: KEY_WIDTH], registered. key_valid rises the cycle after capture into an empty buffer.
  - Handshake is valid & ready. On a transfer key_lane increments.
  - At lane LANES-1 a transfer wraps key_lane to 0, clears the slot, and toggles rd_ptr.
  - key_data must be stable while key_valid=1 and key_ready=0.
- Simultaneous capture and slot release in the same cycle: both take effect. A freed slot can be refilled from the following cycle.
- flush: clears both full flags, rd_ptr, wr_ptr and key_lane next cycle. If a request is outstanding (S_REQ/S_RELEASE), its returning word is captured normally after the flush; the word is not dropped. flush has priority over a same-cycle key transfer.
- underrun: set on key_ready=1 & key_valid=0 & drbg_up=1. Cleared only by reset.
- Requests are not issued while the buffer is full (2 words held); steady-state prefetch depth is 1 word.

Decomposition:
- Shared package drbg_pkg: WORD_WIDTH/KEY_WIDTH defaults and FSM state encodings (S_INIT..S_RELEASE). The package is reused by the DRBG wrapper.
- One natural sub-module: drbg_word_buffer (2-slot buffer, pointers, lane mux, valid/ready). The request FSM stays in the top module.

Test Plan:
The DRBG model returns word n with lane i = {n[15:0], i[15:0]}. It raises next_bits_ready 3 cycles after next_bits and holds it while next_bits=1.
1. Reset release, init_ready rises 10 cycles later -> init high until then; drbg_up=1 next cycle; first key 0x00000000 valid ~5 cycles later; second request issued immediately.
2. key_ready tied 1 -> 16 keys 0x00000000..0x00000007, then 0x00010000..0x00010007, in order, no gaps after the first word, key_lane 0..7 twice, underrun=0.
3. key_ready held 0 with 2 words buffered -> next_bits stays 0, no third capture; key_data stable at 0x00000000.
4. flush mid-word (lane 3) with request outstanding -> key_valid drops for one cycle; the next key is lane 0 of the in-flight word (0x00020000); old keys are never emitted.
5. key_ready=1 before init_ready -> underrun stays 0. A model delaying the word by 20 cycles while key_ready=1 after drbg_up -> underrun=1 and stays 1.
6. Assert reset_n=0 during S_REQ -> next_bits, key_valid and init drop to 0 asynchronously; after release the FSM restarts in S_INIT.
